// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transmit sequencer.
package spi_ctrl_pkg;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 16;
    localparam int NW_W   = 3;

    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_CS_SETUP_CYC = 2;
    localparam int DEF_CS_HOLD_CYC  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_CS_HOLD
    } state_t;

endpackage

// File: rtl/spi_bit_serializer.sv
// Holds the current TX word and presents the bit picked by the index, MSB first.
module spi_bit_serializer
    import spi_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    output logic              o_bit
);

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  w_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_word;
        end
    end

    assign w_sel = IDX_W'(WORD_W - 1) - i_idx;
    assign o_bit = r_word[w_sel];

endmodule

// File: rtl/spi_tx_sequencer.sv
// SPI mode-0 multi-word transmit sequencer with chip-select setup/hold timing.
// Optional MISO capture is enabled by defining SPI_RX_CAPTURE_EN.
module spi_tx_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC
)
(
    input  logic              FPGA_clk,
    input  logic              FPGA_rst,
    input  logic              start,
    input  logic [NW_W-1:0]   num_words,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_phase, w_phase_nxt;
    logic [NW_W-1:0]   r_left, w_left_nxt;
    logic              r_done, w_done_nxt;
    logic              w_load;
    logic              w_rise;
    logic              w_bit;

    always_ff @(posedge FPGA_clk) begin
        if (FPGA_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (FPGA_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_phase <= 1'b0;
            r_left  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_phase <= w_phase_nxt;
            r_left  <= w_left_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_phase_nxt = r_phase;
        w_left_nxt  = r_left;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_rise      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort && (num_words != '0)) begin
                    w_state_nxt = ST_CS_SETUP;
                    w_cnt_nxt   = '0;
                    w_left_nxt  = num_words;
                end
            end
            ST_CS_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_rise      = 1'b1;
                    end else begin
                        // Index only advances as sclk falls, so mosi never moves while high.
                        w_phase_nxt = 1'b0;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            w_left_nxt  = r_left - NW_W'(1);
                            w_state_nxt = (r_left == NW_W'(1)) ? ST_CS_HOLD : ST_LOAD;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_CS_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_phase_nxt = 1'b0;
            w_left_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_load      = 1'b0;
            w_rise      = 1'b0;
        end
    end

    spi_bit_serializer u_ser (
        .i_clk  (FPGA_clk),
        .i_rst  (FPGA_rst),
        .i_load (w_load),
        .i_word (word_data),
        .i_idx  (r_idx),
        .o_bit  (w_bit)
    );

    assign busy       = (r_state != ST_IDLE);
    assign cs_n       = (r_state == ST_IDLE);
    assign sclk       = (r_state == ST_SHIFT) && r_phase;
    assign mosi       = (r_state == ST_SHIFT) && w_bit;
    assign word_ready = (r_state == ST_LOAD);
    assign done       = r_done;

`ifdef SPI_RX_CAPTURE_EN
    logic [WORD_W-1:0] r_rx_sh;
    logic [WORD_W-1:0] r_rx_data;
    logic              r_rx_valid;

    always_ff @(posedge FPGA_clk) begin
        if (FPGA_rst) begin
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load) begin
                r_rx_sh <= '0;
            end else if (w_rise) begin
                r_rx_sh <= {r_rx_sh[WORD_W-2:0], miso};
                if (r_idx == LAST_IDX) begin
                    r_rx_data  <= {r_rx_sh[WORD_W-2:0], miso};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
`else
    logic w_unused_miso;

    assign w_unused_miso = miso;
    assign rx_data       = '0;
    assign rx_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer: vector table plus abort/reset sequences.
module tb_spi_tx_sequencer;

    typedef struct {
        logic [2:0]        nw;
        logic [6:0][15:0]  w;
        int                stall;
        int                exp_busy;
        int                exp_rises;
    } vec_t;

    logic        FPGA_clk = 1'b0;
    logic        FPGA_rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  num_words = 3'd0;
    logic        abort = 1'b0;
    logic [15:0] word_data = 16'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        busy;
    logic        done;
    logic [15:0] rx_data;
    logic        rx_valid;

    always #5 FPGA_clk = ~FPGA_clk;

    spi_tx_sequencer #(
        .CLK_DIV      (2),
        .CS_SETUP_CYC (2),
        .CS_HOLD_CYC  (2)
    ) dut (
        .FPGA_clk   (FPGA_clk),
        .FPGA_rst   (FPGA_rst),
        .start      (start),
        .num_words  (num_words),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .miso       (mosi),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    int checks = 0;
    int passes = 0;

    logic [15:0] sb[$];
    logic [15:0] rxq[$];
    logic [15:0] bits = 16'h0;
    int          nb = 0;
    int          rises = 0;
    int          busy_cyc = 0;
    int          done_cnt = 0;
    int          rxv_cnt = 0;
    int          viol = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;

    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic [15:0] e;
        if (word_ready && word_valid) begin
            sb.push_back(word_data);
            rxq.push_back(word_data);
        end
        @(negedge FPGA_clk);
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (busy === cs_n) viol++;
        if (word_ready && sclk) viol++;
        if (!busy && (sclk || mosi || word_ready)) viol++;
        if (sclk && prev_sclk && (mosi !== prev_mosi)) viol++;
        if (sclk && !prev_sclk) begin
            rises++;
            bits = {bits[14:0], mosi};
            nb++;
            if (nb == 16) begin
                nb = 0;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL mosi_word: got %h with no word pending", bits);
                end else begin
                    e = sb.pop_front();
                    check("mosi_word", 32'(bits), 32'(e));
                end
            end
        end
        if (rx_valid) begin
            rxv_cnt++;
`ifdef SPI_RX_CAPTURE_EN
            if (rxq.size() == 0) begin
                checks++;
                $display("FAIL rx_data: got %h with no word pending", rx_data);
            end else begin
                e = rxq.pop_front();
                check("rx_data", 32'(rx_data), 32'(e));
            end
`endif
        end
        prev_sclk = sclk;
        prev_mosi = mosi;
    endtask

    task automatic flush();
        sb.delete();
        rxq.delete();
        nb = 0;
    endtask

    task automatic clr();
        busy_cyc = 0;
        done_cnt = 0;
        rises = 0;
        rxv_cnt = 0;
        viol = 0;
    endtask

    task automatic run_txn(input vec_t v, input int row);
        int  k;
        int  wt;
        int  cyc;
        bit  hs;
        bit  fin;
        k = 0;
        wt = 0;
        cyc = 0;
        fin = 0;
        clr();
        num_words = v.nw;
        start = 1'b1;
        word_data = v.w[0];
        word_valid = 1'b1;
        tick();
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            if (word_ready && k > 0 && wt < v.stall) begin
                word_valid = 1'b0;
                wt++;
            end else begin
                word_valid = 1'b1;
            end
            word_data = v.w[(k < 7) ? k : 6];
            hs = word_ready && word_valid;
            if (cyc == 20) begin
                start = 1'b1;
                num_words = 3'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (hs) begin
                k++;
                wt = 0;
            end
            if (done) fin = 1;
        end
        start = 1'b0;
        word_valid = 1'b0;
        check($sformatf("r%0d_done_seen", row), 32'(fin), 32'd1);
        repeat (4) tick();
        check($sformatf("r%0d_busy_cycles", row), 32'(busy_cyc), 32'(v.exp_busy));
        check($sformatf("r%0d_done_pulses", row), 32'(done_cnt), 32'd1);
        check($sformatf("r%0d_sclk_rises", row), 32'(rises), 32'(v.exp_rises));
        check($sformatf("r%0d_protocol_viol", row), 32'(viol), 32'd0);
        check($sformatf("r%0d_words_left", row), 32'(sb.size() + nb), 32'd0);
`ifdef SPI_RX_CAPTURE_EN
        check($sformatf("r%0d_rx_pulses", row), 32'(rxv_cnt), 32'(v.nw));
`else
        check($sformatf("r%0d_rx_pulses", row), 32'(rxv_cnt), 32'd0);
`endif
        flush();
    endtask

    task automatic run_until_rises(input logic [2:0] nw, input logic [15:0] w, input int n,
                                   output bit ok);
        int cyc;
        cyc = 0;
        clr();
        num_words = nw;
        word_data = w;
        word_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (rises < n && cyc < 1000) begin
            tick();
            cyc++;
        end
        ok = (rises == n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        vt[0].nw = 3'd1; vt[0].w = '0; vt[0].w[0] = 16'hA5C3;
        vt[0].stall = 0; vt[0].exp_busy = 69; vt[0].exp_rises = 16;

        vt[1].nw = 3'd2; vt[1].w = '0; vt[1].w[0] = 16'h1234; vt[1].w[1] = 16'hFFFF;
        vt[1].stall = 10; vt[1].exp_busy = 144; vt[1].exp_rises = 32;

        vt[2].nw = 3'd3; vt[2].w = '0;
        vt[2].w[0] = 16'h0000; vt[2].w[1] = 16'hFFFF; vt[2].w[2] = 16'h8001;
        vt[2].stall = 0; vt[2].exp_busy = 199; vt[2].exp_rises = 48;

        vt[3].nw = 3'd7;
        vt[3].w[0] = 16'h0001; vt[3].w[1] = 16'h0002; vt[3].w[2] = 16'h4000;
        vt[3].w[3] = 16'h8000; vt[3].w[4] = 16'h7FFE; vt[3].w[5] = 16'hC3C3;
        vt[3].w[6] = 16'h3C3C;
        vt[3].stall = 0; vt[3].exp_busy = 459; vt[3].exp_rises = 112;

        vt[4].nw = 3'd2; vt[4].w = '0; vt[4].w[0] = 16'hDEAD; vt[4].w[1] = 16'hBEEF;
        vt[4].stall = 3; vt[4].exp_busy = 137; vt[4].exp_rises = 32;

        FPGA_rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {7'(0), cs_n, sclk, mosi, busy, done, word_ready, rx_valid, rx_data},
              {7'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
        FPGA_rst = 1'b0;
        flush();
        tick();

        run_txn(vt[0], 0);
        run_txn(vt[1], 1);

        clr();
        num_words = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("nw0_busy_cycles", 32'(busy_cyc), 32'd0);
        check("nw0_outputs", {27'(0), cs_n, sclk, mosi, done, word_ready},
              {27'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        clr();
        num_words = 3'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();
        check("idle_abort_start_busy", 32'(busy_cyc + done_cnt), 32'd0);

        run_until_rises(3'd1, 16'h8001, 5, ok);
        check("abort_reached_rise5", 32'(ok), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        word_valid = 1'b0;
        check("abort_outputs", {27'(0), cs_n, sclk, mosi, busy, word_ready},
              {27'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        flush();
        clr();
        repeat (6) tick();
        check("abort_no_done", 32'(done_cnt + rxv_cnt + busy_cyc), 32'd0);

        run_txn(vt[2], 2);
        run_txn(vt[3], 3);

        run_until_rises(3'd2, 16'hAAAA, 8, ok);
        check("rst_reached_rise8", 32'(ok), 32'd1);
        FPGA_rst = 1'b1;
        tick();
        check("midrst_outputs",
              {7'(0), cs_n, sclk, mosi, busy, done, word_ready, rx_valid, rx_data},
              {7'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
        FPGA_rst = 1'b0;
        word_valid = 1'b0;
        flush();
        clr();
        repeat (8) tick();
        check("midrst_no_done", 32'(done_cnt + busy_cyc), 32'd0);

        run_txn(vt[4], 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
